mux_merge_2t1_nb: RTL and testbench

- Registered 2:1 merge block: combines two independent valid/ready source channels onto one output channel.
- Return path for the 1-to-2 routing mux. Two producers (e.g. two peripheral/ALU result paths) share one consumer port of the RAT datapath.
- Round-robin arbitration and a one-entry output register. Each output word is tagged with its source channel.

---
 rtl/mux_merge_2t1_nb.sv | 134 +++++++++++++
 tb/tb_mux_merge_2t1_nb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_merge_2t1_nb.sv
// rtl/mux_merge_2t1_nb.sv - registered 2:1 valid/ready merge with source tag
//
// Merges two independent valid/ready producer channels onto one registered
// consumer channel. Arbitration is round-robin by default. Each output word
// carries a tag naming the channel it came from.
//
// Configuration macro:
//   MUX_MERGE_FIXED_PRIO_EN - when defined, channel 0 always wins contention
//                             and the round-robin pointer is ignored.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   D0/VALID0  in   channel-0 data / valid
//   READY0     out  channel-0 accepted when VALID0 && READY0
//   D1/VALID1  in   channel-1 data / valid
//   READY1     out  channel-1 accepted when VALID1 && READY1
//   D_OUT      out  merged data (registered)
//   SRC        out  source channel of D_OUT (registered)
//   VALID_OUT  out  D_OUT/SRC hold a word (registered)
//   READY_OUT  in   consumer accepts when VALID_OUT && READY_OUT
module mux_merge_2t1_nb #(
  parameter int n = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [n-1:0] D0,
  input  logic         VALID0,
  output logic         READY0,
  input  logic [n-1:0] D1,
  input  logic         VALID1,
  output logic         READY1,
  output logic [n-1:0] D_OUT,
  output logic         SRC,
  output logic         VALID_OUT,
  input  logic         READY_OUT
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         last;
  logic [n-1:0] data_q;
  logic         src_q;

  logic pop;
  logic load_ok;
  logic grant0;
  logic grant1;
  logic xfer0;
  logic xfer1;
  logic xfer;

  assign VALID_OUT = (state == FULL);
  assign D_OUT     = data_q;
  assign SRC       = src_q;

  // The output register may be refilled in the same cycle it is popped,
  // which is what gives one word per cycle without bubbles.
  assign pop     = VALID_OUT && READY_OUT;
  assign load_ok = !VALID_OUT || pop;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (VALID0 && !VALID1) begin
      grant0 = 1'b1;
    end else if (VALID1 && !VALID0) begin
      grant1 = 1'b1;
    end else if (VALID0 && VALID1) begin
`ifdef MUX_MERGE_FIXED_PRIO_EN
      grant0 = 1'b1;
`else
      // Grant whichever channel did not win the previous transfer.
      grant0 = last;
      grant1 = !last;
`endif
    end
  end

  // Gated by RST_N so both readies drop the moment reset asserts.
  assign READY0 = load_ok && grant0 && RST_N;
  assign READY1 = load_ok && grant1 && RST_N;

  assign xfer0 = VALID0 && READY0;
  assign xfer1 = VALID1 && READY1;
  assign xfer  = xfer0 || xfer1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (xfer) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (xfer) begin
          state_nxt = FULL;
        end else if (READY_OUT) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Data, tag and priority pointer change only on an accepted transfer;
  // a pop alone leaves D_OUT/SRC holding their last value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q <= '0;
      src_q  <= 1'b0;
      last   <= 1'b1;
    end else if (xfer) begin
      data_q <= xfer1 ? D1 : D0;
      src_q  <= xfer1;
      last   <= xfer1;
    end
  end

endmodule

// File: tb/tb_mux_merge_2t1_nb.sv
// tb/tb_mux_merge_2t1_nb.sv - directed self-checking bench for mux_merge_2t1_nb
module tb_mux_merge_2t1_nb;

`ifdef MUX_MERGE_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       CLK;
  logic       RST_N;
  logic [7:0] D0;
  logic       VALID0;
  logic       READY0;
  logic [7:0] D1;
  logic       VALID1;
  logic       READY1;
  logic [7:0] D_OUT;
  logic       SRC;
  logic       VALID_OUT;
  logic       READY_OUT;

  int compared;
  int mismatched;

  mux_merge_2t1_nb #(.n(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .D0        (D0),
    .VALID0    (VALID0),
    .READY0    (READY0),
    .D1        (D1),
    .VALID1    (VALID1),
    .READY1    (READY1),
    .D_OUT     (D_OUT),
    .SRC       (SRC),
    .VALID_OUT (VALID_OUT),
    .READY_OUT (READY_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return to the following falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    logic exp_src;
    compared   = 0;
    mismatched = 0;
    RST_N      = 1'b0;
    D0         = 8'h00;
    D1         = 8'h00;
    VALID0     = 1'b1;
    VALID1     = 1'b1;
    READY_OUT  = 1'b1;

    // Reset state, with both sources already requesting.
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("rst_valid_out", 32'(VALID_OUT), 32'h0);
    check("rst_d_out", 32'(D_OUT), 32'h0);
    check("rst_src", 32'(SRC), 32'h0);
    check("rst_ready0", 32'(READY0), 32'h0);
    check("rst_ready1", 32'(READY1), 32'h0);

    // Contention round-robin: 5 transfers, SRC 0,1,0,1,0.
    @(negedge CLK);
    RST_N = 1'b1;
    D0    = 8'hA0;
    D1    = 8'hB1;
    exp_src = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_ready0", 32'(READY0), 32'(!exp_src));
      check("rr_ready1", 32'(READY1), 32'(exp_src));
      check("rr_not_both", 32'(READY0 && READY1), 32'h0);
      step();
      check("rr_valid", 32'(VALID_OUT), 32'h1);
      check("rr_src", 32'(SRC), 32'(exp_src));
      check("rr_data", 32'(D_OUT), exp_src ? 32'hB1 : 32'hA0);
      exp_src = FIXED ? 1'b0 : !exp_src;
    end

    // Asynchronous reset mid-cycle while holding a word.
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_valid_out", 32'(VALID_OUT), 32'h0);
    check("arst_d_out", 32'(D_OUT), 32'h0);
    check("arst_src", 32'(SRC), 32'h0);
    check("arst_ready0", 32'(READY0), 32'h0);
    check("arst_ready1", 32'(READY1), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("post_rst_ready0", 32'(READY0), 32'h1);
    check("post_rst_ready1", 32'(READY1), 32'h0);
    step();
    check("post_rst_src", 32'(SRC), 32'h0);
    check("post_rst_data", 32'(D_OUT), 32'hA0);

    // Pop with no transfer: VALID_OUT drops, data and tag hold.
    VALID0 = 1'b0;
    VALID1 = 1'b0;
    step();
    check("drain_valid", 32'(VALID_OUT), 32'h0);
    check("drain_hold_data", 32'(D_OUT), 32'hA0);
    check("drain_hold_src", 32'(SRC), 32'h0);

    // Single-channel streaming on channel 1, no bubbles.
    VALID1 = 1'b1;
    D1     = 8'h11;
    #1;
    check("stream_ready1", 32'(READY1), 32'h1);
    step();
    check("stream_v0", 32'(VALID_OUT), 32'h1);
    check("stream_d0", 32'(D_OUT), 32'h11);
    check("stream_s0", 32'(SRC), 32'h1);
    D1 = 8'h22;
    step();
    check("stream_v1", 32'(VALID_OUT), 32'h1);
    check("stream_d1", 32'(D_OUT), 32'h22);
    D1 = 8'h33;
    step();
    check("stream_v2", 32'(VALID_OUT), 32'h1);
    check("stream_d2", 32'(D_OUT), 32'h33);
    check("stream_s2", 32'(SRC), 32'h1);
    VALID1 = 1'b0;
    step();
    check("stream_end", 32'(VALID_OUT), 32'h0);

    // Backpressure: 0x5A held while channel 1 waits with 0x77.
    VALID0    = 1'b1;
    D0        = 8'h5A;
    READY_OUT = 1'b0;
    step();
    check("bp_load_data", 32'(D_OUT), 32'h5A);
    check("bp_load_src", 32'(SRC), 32'h0);
    VALID0 = 1'b0;
    VALID1 = 1'b1;
    D1     = 8'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_ready1", 32'(READY1), 32'h0);
      check("bp_ready0", 32'(READY0), 32'h0);
      check("bp_valid", 32'(VALID_OUT), 32'h1);
      check("bp_data", 32'(D_OUT), 32'h5A);
      step();
    end
    READY_OUT = 1'b1;
    #1;
    check("bp_release_ready1", 32'(READY1), 32'h1);
    step();
    check("bp_out_data", 32'(D_OUT), 32'h77);
    check("bp_out_src", 32'(SRC), 32'h1);
    check("bp_out_valid", 32'(VALID_OUT), 32'h1);

    // Pop with simultaneous load.
    VALID1 = 1'b0;
    VALID0 = 1'b1;
    D0     = 8'hC3;
    #1;
    check("pl_ready0", 32'(READY0), 32'h1);
    step();
    check("pl_data", 32'(D_OUT), 32'hC3);
    check("pl_src", 32'(SRC), 32'h0);
    check("pl_valid", 32'(VALID_OUT), 32'h1);
    VALID0 = 1'b0;
    step();
    check("pl_drain", 32'(VALID_OUT), 32'h0);

    // Idle cycles leave priority alone: channel 0 won last, so channel 1 is next.
    step();
    step();
    VALID0 = 1'b1;
    VALID1 = 1'b1;
    D0     = 8'h0F;
    D1     = 8'hF0;
    #1;
    check("idle_ready0", 32'(READY0), FIXED ? 32'h1 : 32'h0);
    check("idle_ready1", 32'(READY1), FIXED ? 32'h0 : 32'h1);
    step();
    check("idle_src", 32'(SRC), FIXED ? 32'h0 : 32'h1);
    check("idle_data", 32'(D_OUT), FIXED ? 32'h0F : 32'hF0);
    VALID0 = 1'b0;
    VALID1 = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
